video_timing_ctrl: RTL and testbench
====================================

Name: video_timing_ctrl

Overview:
Parametrised pixel-domain display controller, successor to the fixed 800x480 VGA controller. Generates HS/VS/BLANK from compile-time timing parameters with selectable sync polarity. Pops a show-ahead pixel FIFO during the active area and starts only after a synchronised start request, at a frame boundary. Adds underflow detection, substitute colour, frame/line markers and pixel coordinates. Sits between the async pixel FIFO (read side) and the video_if master.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, HS pulse width (pixels)
HBP, 40, horizontal back porch (pixels)
VFP, 13, vertical front porch (lines)
VPULSE, 3, VS pulse width (lines)
VBP, 29, vertical back porch (lines)
HS_POL, 0, asserted level of HS
VS_POL, 0, asserted level of VS
DATA_W, 24, pixel width
UFLOW_COLOR, 24'hFF00FF, pixel driven on underflow (DATA_W bits)

Ports:
pixel_clk  in  1  pixel clock
pixel_rst  in  1  asynchronous, active-high reset
start_async  in  1  start request from another domain (e.g. FIFO wfull), level
fifo_rdata  in  DATA_W  show-ahead FIFO head word, valid when !fifo_rempty
fifo_rempty  in  1  FIFO empty
fifo_read  out  1  pop FIFO head this cycle
RGB  out  DATA_W  pixel data
HS  out  1  horizontal sync
VS  out  1  vertical sync
BLANK  out  1  1 = active pixel (video_if convention)
frame_start  out  1  one-cycle pulse with first active pixel of a frame
line_start  out  1  one-cycle pulse with first active pixel of each active line
pix_x  out  clog2(HTOTAL)  horizontal coordinate of current output
pix_y  out  clog2(VTOTAL)  vertical coordinate of current output
running  out  1  controller started
uflow_sticky  out  1  underflow has occurred since reset
uflow_cnt  out  16  underflow pixel count, saturating at 16'hFFFF

Behaviour:
- HTOTAL=HDISP+HFP+HPULSE+HBP, VTOTAL=VDISP+VFP+VPULSE+VBP; counters h 0..HTOTAL-1, v 0..VTOTAL-1; h wraps to 0 and v increments at h==HTOTAL-1; v wraps to 0 at v==VTOTAL-1 and h==HTOTAL-1.
- Line layout: active h<HDISP, then FP, sync at HDISP+HFP<=h<HDISP+HFP+HPULSE, then BP. Frame layout same with v/VDISP/VFP/VPULSE.
- start_async through 2-FF synchroniser; running set on first synchronised high, sticky until reset (later deassertion ignored). While !running: h=v=0 held, outputs idle. First counted cycle after running rises is h=0,v=0.
- Outputs registered, 1-cycle latency from counters: BLANK=(h<HDISP&&v<VDISP); HS=HS_POL in sync region else ~HS_POL; VS likewise with VS_POL; pix_x/pix_y = registered h/v.
- frame_start=1 when registered h==0&&v==0; line_start=1 when registered h==0&&v<VDISP; both only while running.
- fifo_read = BLANK & ~fifo_rempty (combinational). RGB = BLANK ? (fifo_rempty ? UFLOW_COLOR : fifo_rdata) : 0.
- Underflow: BLANK & fifo_rempty on a cycle -> uflow_sticky<=1, uflow_cnt+1 (saturate). Timing never stalls; missing pixel not re-read.
- Reset (any time, mid-frame included): h,v,running,sync pipeline=0; BLANK=0, HS=~HS_POL, VS=~VS_POL, frame_start=line_start=0, pix_x=pix_y=0, uflow_sticky=0, uflow_cnt=0. fifo_read therefore 0.
- Elaboration check: all porches/pulses >=1, HDISP,VDISP>=1; $error otherwise.

Decomposition:
- Package video_timing_pkg: localparam functions htotal()/vtotal(), counter-width helpers, default timing constants for 800x480, typedef for pixel word.
- Sub-module sync_2ff (single-bit 2-FF synchroniser, async reset) for start_async; reused by other pixel-domain blocks.

Test Plan:
- Reset then start_async=1 at cycle 10 -> running high at cycle 12; first frame_start with BLANK=1 one cycle after first counted cycle; HS/VS/BLANK idle before.
- Defaults, FIFO never empty -> HS period 928 cycles, HS low 48 cycles starting 840 after line_start; VS low 3 lines (2784 cycles); 800 BLANK=1 cycles per line, 384000 fifo_read per frame, 525 lines per frame.
- HS_POL=1, VS_POL=1, HDISP=16, VDISP=4, porches 2/2/2 -> HTOTAL 22, VTOTAL 10; HS high 2 cycles per line, reset value HS=0.
- Empty FIFO for 5 active cycles mid-line -> RGB=FF00FF on those cycles, fifo_read=0, uflow_cnt=5, uflow_sticky=1, sync timing unchanged.
- Preload uflow_cnt near 16'hFFFF via long empty run -> saturates at 16'hFFFF; start_async toggling low after start -> no effect.
- pixel_rst asserted mid-line (h=300,v=100) -> all outputs to reset values immediately; after release and new start, frame restarts at h=0,v=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants, pixel type and counter-width helpers for pixel-domain video blocks.
// Defaults describe the 800x480 panel that the fixed controller used to target.
package video_timing_pkg;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;
    localparam int DEF_DATA_W = 24;
    localparam logic [DEF_DATA_W-1:0] DEF_UFLOW_COLOR = 24'hFF00FF;

    typedef logic [DEF_DATA_W-1:0] pixel_t;

    function automatic int htotal(input int disp, input int fp, input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

    function automatic int vtotal(input int disp, input int fp, input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

    // Bits needed to hold 0..total-1.
    function automatic int cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
// The input must be a level; pulses shorter than two destination clocks may be lost.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/video_timing_ctrl.sv
// Parametrised display timing generator: HS/VS/BLANK, show-ahead FIFO pop, underflow
// substitution and counting, frame/line markers and pixel coordinates.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int VDISP  = DEF_VDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] UFLOW_COLOR = DATA_W'(DEF_UFLOW_COLOR),
    localparam int HTOTAL = htotal(HDISP, HFP, HPULSE, HBP),
    localparam int VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP),
    localparam int HW     = cnt_w(HTOTAL),
    localparam int VW     = cnt_w(VTOTAL)
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    input  logic              start_async,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_rempty,
    output logic              fifo_read,
    output logic [DATA_W-1:0] RGB,
    output logic              HS,
    output logic              VS,
    output logic              BLANK,
    output logic              frame_start,
    output logic              line_start,
    output logic [HW-1:0]     pix_x,
    output logic [VW-1:0]     pix_y,
    output logic              running,
    output logic              uflow_sticky,
    output logic [15:0]       uflow_cnt
);

    localparam logic [HW-1:0] H_ACT_END  = HW'(HDISP);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HDISP + HFP + HPULSE);
    localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(VDISP);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VDISP + VFP + VPULSE);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);

    if (HDISP < 1 || VDISP < 1 || HFP < 1 || HPULSE < 1 || HBP < 1 ||
        VFP < 1 || VPULSE < 1 || VBP < 1) begin : g_bad_timing
        $error("video_timing_ctrl: every display, porch and pulse parameter must be >= 1");
    end

    logic          w_start_sync;
    logic          r_running;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_blank;
    logic          r_hs;
    logic          r_vs;
    logic          r_frame_start;
    logic          r_line_start;
    logic [HW-1:0] r_pix_x;
    logic [VW-1:0] r_pix_y;
    logic          r_uflow_sticky;
    logic [15:0]   r_uflow_cnt;

    logic w_h_act;
    logic w_v_act;
    logic w_hs_act;
    logic w_vs_act;
    logic w_h_zero;
    logic w_underflow;

    sync_2ff u_start_sync (
        .i_clk (pixel_clk),
        .i_rst (pixel_rst),
        .i_d   (start_async),
        .o_q   (w_start_sync)
    );

    // Counters hold at the origin until started, so the first counted cycle is h=0,v=0.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_running <= 1'b0;
            r_h       <= '0;
            r_v       <= '0;
        end else begin
            if (w_start_sync) begin
                r_running <= 1'b1;
            end
            if (r_running) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
                end else begin
                    r_h <= r_h + HW'(1);
                end
            end
        end
    end

    assign w_h_act     = (r_h < H_ACT_END);
    assign w_v_act     = (r_v < V_ACT_END);
    assign w_hs_act    = r_running && (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
    assign w_vs_act    = r_running && (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);
    assign w_h_zero    = (r_h == '0);
    assign w_underflow = r_blank & fifo_rempty;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_blank        <= 1'b0;
            r_hs           <= ~HS_POL;
            r_vs           <= ~VS_POL;
            r_frame_start  <= 1'b0;
            r_line_start   <= 1'b0;
            r_pix_x        <= '0;
            r_pix_y        <= '0;
            r_uflow_sticky <= 1'b0;
            r_uflow_cnt    <= '0;
        end else begin
            r_blank       <= r_running && w_h_act && w_v_act;
            r_hs          <= w_hs_act ? HS_POL : ~HS_POL;
            r_vs          <= w_vs_act ? VS_POL : ~VS_POL;
            r_frame_start <= r_running && w_h_zero && (r_v == '0);
            r_line_start  <= r_running && w_h_zero && w_v_act;
            r_pix_x       <= r_h;
            r_pix_y       <= r_v;
            // Timing never stalls on an empty FIFO; the missing pixel is replaced and counted.
            if (w_underflow) begin
                r_uflow_sticky <= 1'b1;
                if (r_uflow_cnt != 16'hFFFF) begin
                    r_uflow_cnt <= r_uflow_cnt + 16'd1;
                end
            end
        end
    end

    assign fifo_read    = r_blank & ~fifo_rempty;
    assign RGB          = r_blank ? (fifo_rempty ? UFLOW_COLOR : fifo_rdata) : '0;
    assign BLANK        = r_blank;
    assign HS           = r_hs;
    assign VS           = r_vs;
    assign frame_start  = r_frame_start;
    assign line_start   = r_line_start;
    assign pix_x        = r_pix_x;
    assign pix_y        = r_pix_y;
    assign running      = r_running;
    assign uflow_sticky = r_uflow_sticky;
    assign uflow_cnt    = r_uflow_cnt;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench: a small 16x4 instance (positive sync), a default 800x480 instance for
// line timing, and a 200x200 always-empty instance for underflow counter saturation.
module tb_video_timing_ctrl;
    import video_timing_pkg::*;

    logic pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    // small instance: HTOTAL 22, VTOTAL 10, HS sync h 18..19, VS sync v 6..7
    logic        a_rst, a_start, a_rempty;
    pixel_t      a_rdata;
    logic        a_read, a_hs, a_vs, a_blank, a_fs, a_ls, a_running, a_sticky;
    pixel_t      a_rgb;
    logic [4:0]  a_px;
    logic [3:0]  a_py;
    logic [15:0] a_ucnt;

    video_timing_ctrl #(
        .HDISP(16), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
        .VFP(2), .VPULSE(2), .VBP(2), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut (
        .pixel_clk(pixel_clk), .pixel_rst(a_rst), .start_async(a_start),
        .fifo_rdata(a_rdata), .fifo_rempty(a_rempty), .fifo_read(a_read),
        .RGB(a_rgb), .HS(a_hs), .VS(a_vs), .BLANK(a_blank),
        .frame_start(a_fs), .line_start(a_ls), .pix_x(a_px), .pix_y(a_py),
        .running(a_running), .uflow_sticky(a_sticky), .uflow_cnt(a_ucnt)
    );

    // default-timing instance, FIFO never empty
    logic        d_rst, d_start;
    logic        d_read, d_hs, d_vs, d_blank, d_fs, d_ls, d_running, d_sticky;
    pixel_t      d_rgb;
    logic [9:0]  d_px, d_py;
    logic [15:0] d_ucnt;

    video_timing_ctrl u_dflt (
        .pixel_clk(pixel_clk), .pixel_rst(d_rst), .start_async(d_start),
        .fifo_rdata(24'h0A0B0C), .fifo_rempty(1'b0), .fifo_read(d_read),
        .RGB(d_rgb), .HS(d_hs), .VS(d_vs), .BLANK(d_blank),
        .frame_start(d_fs), .line_start(d_ls), .pix_x(d_px), .pix_y(d_py),
        .running(d_running), .uflow_sticky(d_sticky), .uflow_cnt(d_ucnt)
    );

    // 200x200 instance, porches 1, FIFO always empty: 40000 active cycles per 41209-cycle frame
    logic        s_rst, s_start;
    logic        s_read, s_hs, s_vs, s_blank, s_fs, s_ls, s_running, s_sticky;
    pixel_t      s_rgb;
    logic [7:0]  s_px, s_py;
    logic [15:0] s_ucnt;

    video_timing_ctrl #(
        .HDISP(200), .VDISP(200), .HFP(1), .HPULSE(1), .HBP(1),
        .VFP(1), .VPULSE(1), .VBP(1)
    ) u_sat (
        .pixel_clk(pixel_clk), .pixel_rst(s_rst), .start_async(s_start),
        .fifo_rdata(24'h0), .fifo_rempty(1'b1), .fifo_read(s_read),
        .RGB(s_rgb), .HS(s_hs), .VS(s_vs), .BLANK(s_blank),
        .frame_start(s_fs), .line_start(s_ls), .pix_x(s_px), .pix_y(s_py),
        .running(s_running), .uflow_sticky(s_sticky), .uflow_cnt(s_ucnt)
    );

    int          s_frames = 0;
    logic [15:0] s_snap_cnt = '0;
    int unsigned s_snap_cyc = 0;
    always @(negedge pixel_clk) begin
        if (s_fs === 1'b1) begin
            s_frames = s_frames + 1;
            if (s_frames == 2) begin
                s_snap_cnt = s_ucnt;
                s_snap_cyc = cyc;
            end
        end
    end

    function automatic logic [56:0] a_idle_vec();
        return {a_blank, a_hs, a_vs, a_fs, a_ls, a_read, a_running, a_sticky,
                a_px, a_py, a_ucnt, a_rgb};
    endfunction

    task automatic test_reset();
        a_rst = 1'b1; a_start = 1'b0; a_rempty = 1'b0; a_rdata = 24'h123456;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        checks++;
        if (a_idle_vec() !== 57'h0) begin
            errors++;
            $display("FAIL reset_vals: got %h expected %h", a_idle_vec(), 57'h0);
        end
        @(posedge pixel_clk); #1 a_rst = 1'b0;
        repeat (5) @(negedge pixel_clk);
        checks++;
        if (a_idle_vec() !== 57'h0) begin
            errors++;
            $display("FAIL idle_unstarted: got %h expected %h", a_idle_vec(), 57'h0);
        end
    endtask

    task automatic test_start();
        @(posedge pixel_clk); #1 a_start = 1'b1;
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        checks++;
        if (a_running !== 1'b0) begin
            errors++; $display("FAIL start_sync_early: running got %b expected 0", a_running);
        end
        @(negedge pixel_clk);
        checks++;
        if ({a_running, a_blank, a_fs} !== 3'b100) begin
            errors++; $display("FAIL start_running: {run,blank,fs} got %b expected 100", {a_running, a_blank, a_fs});
        end
        @(negedge pixel_clk);
        checks++;
        if ({a_blank, a_fs, a_ls, a_px, a_py} !== {3'b111, 5'd0, 4'd0}) begin
            errors++;
            $display("FAIL first_frame_start: {blank,fs,ls,x,y} got %b expected %b",
                     {a_blank, a_fs, a_ls, a_px, a_py}, {3'b111, 9'd0});
        end
    endtask

    // Two full frames from the first counted output cycle.
    task automatic test_frame();
        int h, v, n_blank, n_hs, n_vs, n_fs;
        logic eb, ehs, evs, efs, els;
        logic [38:0] got, exp;
        n_blank = 0; n_hs = 0; n_vs = 0; n_fs = 0;
        for (int i = 0; i < 440; i++) begin
            if (i > 0) @(negedge pixel_clk);
            h = i % 22; v = (i / 22) % 10;
            eb  = (h < 16) && (v < 4);
            ehs = (h >= 18) && (h < 20);
            evs = (v >= 6) && (v < 8);
            efs = (h == 0) && (v == 0);
            els = (h == 0) && (v < 4);
            exp = {eb, ehs, evs, efs, els, eb, 5'(h), 4'(v), eb ? 24'h123456 : 24'h0};
            got = {a_blank, a_hs, a_vs, a_fs, a_ls, a_read, a_px, a_py, a_rgb};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL frame_vec i=%0d: got %h expected %h", i, got, exp);
            end
            if (i < 220) begin
                n_blank += int'(a_blank); n_hs += int'(a_hs); n_vs += int'(a_vs);
            end
            n_fs += int'(a_fs);
        end
        checks++;
        if (n_blank != 64) begin errors++; $display("FAIL blank_per_frame: got %0d expected 64", n_blank); end
        checks++;
        if (n_hs != 20) begin errors++; $display("FAIL hs_high_per_frame: got %0d expected 20", n_hs); end
        checks++;
        if (n_vs != 44) begin errors++; $display("FAIL vs_high_per_frame: got %0d expected 44", n_vs); end
        checks++;
        if (n_fs != 2) begin errors++; $display("FAIL frame_starts: got %0d expected 2", n_fs); end
    endtask

    task automatic test_underflow();
        int n = 0;
        logic [26:0] got, exp;
        do begin @(negedge pixel_clk); n++; end while (a_ls !== 1'b1 && n < 100);
        checks++;
        if ({a_ls, a_px, a_sticky, a_ucnt} !== {1'b1, 5'd0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL uf_pre: {ls,x,sticky,cnt} got %h expected %h",
                     {a_ls, a_px, a_sticky, a_ucnt}, {1'b1, 5'd0, 1'b0, 16'd0});
        end
        repeat (5) @(posedge pixel_clk);
        #1 a_rempty = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge pixel_clk);
            got = {a_blank, a_read, a_rgb, a_hs};
            exp = {1'b1, 1'b0, 24'hFF00FF, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL uf_mid k=%0d: got %h expected %h", k, got, exp);
            end
            @(posedge pixel_clk); #1;
        end
        a_rempty = 1'b0;
        @(negedge pixel_clk);
        checks++;
        if ({a_ucnt, a_sticky, a_px, a_read} !== {16'd5, 1'b1, 5'd10, 1'b1}) begin
            errors++;
            $display("FAIL uf_count5: {cnt,sticky,x,read} got %h expected %h",
                     {a_ucnt, a_sticky, a_px, a_read}, {16'd5, 1'b1, 5'd10, 1'b1});
        end
        repeat (4) @(posedge pixel_clk);
        #1 a_rempty = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge pixel_clk);
            got = {a_blank, a_read, a_rgb, a_hs};
            exp = {k < 2, 1'b0, (k < 2) ? 24'hFF00FF : 24'h0, (k >= 4)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL uf_edge h=%0d: got %h expected %h", 14 + k, got, exp);
            end
            @(posedge pixel_clk); #1;
        end
        a_rempty = 1'b0;
        @(negedge pixel_clk);
        checks++;
        if ({a_ucnt, a_px, a_py} !== {16'd7, 5'd20, 4'd0}) begin
            errors++;
            $display("FAIL uf_count7: {cnt,x,y} got %h expected %h",
                     {a_ucnt, a_px, a_py}, {16'd7, 5'd20, 4'd0});
        end
    endtask

    task automatic test_start_ignore();
        @(posedge pixel_clk); #1 a_start = 1'b0;
        repeat (10) @(negedge pixel_clk);
        checks++;
        if ({a_running, a_px, a_py} !== {1'b1, 5'd8, 4'd1}) begin
            errors++;
            $display("FAIL start_ignore: {run,x,y} got %h expected %h",
                     {a_running, a_px, a_py}, {1'b1, 5'd8, 4'd1});
        end
    endtask

    task automatic test_reset_midline();
        repeat (24) @(negedge pixel_clk);
        checks++;
        if ({a_blank, a_px, a_py} !== {1'b1, 5'd10, 4'd2}) begin
            errors++;
            $display("FAIL pre_rst_pos: {blank,x,y} got %h expected %h",
                     {a_blank, a_px, a_py}, {1'b1, 5'd10, 4'd2});
        end
        #2 a_rst = 1'b1;
        #1;
        checks++;
        if (a_idle_vec() !== 57'h0) begin
            errors++; $display("FAIL midline_reset: got %h expected %h", a_idle_vec(), 57'h0);
        end
        @(posedge pixel_clk); #1 a_rst = 1'b0;
        repeat (4) @(negedge pixel_clk);
        checks++;
        if (a_idle_vec() !== 57'h0) begin
            errors++; $display("FAIL post_rst_idle: got %h expected %h", a_idle_vec(), 57'h0);
        end
        test_start();
    endtask

    task automatic test_default_hsync();
        int n = 0, first_fall = -1, second_fall = -1, next_ls = -1;
        int low_cnt = 0, blank_cnt = 0, read_cnt = 0;
        logic prev_hs;
        do begin @(negedge pixel_clk); n++; end while (d_ls !== 1'b1 && n < 1000);
        checks++;
        if (d_ls !== 1'b1) begin errors++; $display("FAIL dflt_ls_wait: line_start got %b expected 1", d_ls); end
        prev_hs = d_hs;
        for (int c = 0; c < 1800; c++) begin
            if (c > 0) @(negedge pixel_clk);
            if (c < 928) begin
                low_cnt += int'(!d_hs); blank_cnt += int'(d_blank); read_cnt += int'(d_read);
            end
            if (c > 0 && d_ls && next_ls < 0) next_ls = c;
            if (prev_hs && !d_hs) begin
                if (first_fall < 0) first_fall = c;
                else if (second_fall < 0) second_fall = c;
            end
            prev_hs = d_hs;
        end
        checks++;
        if (first_fall != 840) begin errors++; $display("FAIL dflt_hs_offset: got %0d expected 840", first_fall); end
        checks++;
        if (low_cnt != 48) begin errors++; $display("FAIL dflt_hs_width: got %0d expected 48", low_cnt); end
        checks++;
        if (second_fall != 1768) begin errors++; $display("FAIL dflt_hs_period: got %0d expected 1768", second_fall); end
        checks++;
        if (next_ls != 928) begin errors++; $display("FAIL dflt_line_period: got %0d expected 928", next_ls); end
        checks++;
        if (blank_cnt != 800) begin errors++; $display("FAIL dflt_blank_cnt: got %0d expected 800", blank_cnt); end
        checks++;
        if (read_cnt != 800) begin errors++; $display("FAIL dflt_read_cnt: got %0d expected 800", read_cnt); end
    endtask

    task automatic test_saturation();
        int n = 0;
        while (s_frames < 2 && n < 60000) begin @(negedge pixel_clk); n++; end
        checks++;
        if (s_frames < 2) begin
            errors++; $display("FAIL sat_frame_wait: frames got %0d expected 2", s_frames);
            return;
        end
        checks++;
        if (s_snap_cnt !== 16'd40000) begin
            errors++; $display("FAIL sat_one_frame: got %0d expected 40000", s_snap_cnt);
        end
        n = 0;
        while (cyc != s_snap_cyc + 20000 && n < 30000) begin @(negedge pixel_clk); n++; end
        checks++;
        if ({s_ucnt, s_blank, s_read, s_rgb} !== {16'd59706, 1'b1, 1'b0, 24'hFF00FF}) begin
            errors++;
            $display("FAIL sat_partial: {cnt,blank,read,rgb} got %h expected %h",
                     {s_ucnt, s_blank, s_read, s_rgb}, {16'd59706, 1'b1, 1'b0, 24'hFF00FF});
        end
        n = 0;
        while (cyc != s_snap_cyc + 27000 && n < 10000) begin @(negedge pixel_clk); n++; end
        checks++;
        if ({s_ucnt, s_sticky} !== {16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL sat_limit: {cnt,sticky} got %h expected %h", {s_ucnt, s_sticky}, {16'hFFFF, 1'b1});
        end
    endtask

    initial begin
        d_rst = 1'b1; s_rst = 1'b1; d_start = 1'b0; s_start = 1'b0;
        test_reset();
        d_rst = 1'b0; s_rst = 1'b0;
        d_start = 1'b1; s_start = 1'b1;
        test_start();
        test_frame();
        test_underflow();
        test_start_ignore();
        test_reset_midline();
        test_default_hsync();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
